memory_stage: RTL and testbench

RV32I pipeline Memory stage. It sits directly downstream of the Execute stage and consumes its ALU result, store data and control bits. It contains the byte-addressed data memory with byte/half/word loads and stores, and the MEM/WB pipeline register. It also returns ALUResultM combinationally for EX forwarding, and ResultW from the writeback mux for the register file and forwarding.

---
 rtl/memory_stage.sv | 163 ++++++++++++++++
 tb/tb_memory_stage.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// RV32I Memory stage: byte-addressed data memory with sized, sign/zero-extended
// loads and byte-lane stores, the MEM/WB pipeline register and the writeback mux.
module memory_stage #(
  parameter int D_WIDTH     = 32,
  parameter int A_WIDTH     = 5,
  parameter int DMEM_ADDR_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               RegWriteM_i,
  input  logic [1:0]         ResultSrcM_i,
  input  logic               MemWriteM,
  input  logic [2:0]         Funct3M,
  input  logic [D_WIDTH-1:0] ALUResultM_i,
  input  logic [D_WIDTH-1:0] WriteDataM,
  input  logic [A_WIDTH-1:0] RdM_i,
  input  logic [D_WIDTH-1:0] PCplus4M_i,
  output logic [D_WIDTH-1:0] ALUResultM_o,
  output logic               RegWriteW,
  output logic [1:0]         ResultSrcW,
  output logic [D_WIDTH-1:0] ALUResultW,
  output logic [D_WIDTH-1:0] ReadDataW,
  output logic [D_WIDTH-1:0] PCplus4W,
  output logic [A_WIDTH-1:0] RdW,
  output logic               MisalignW,
  output logic [D_WIDTH-1:0] ResultW
);

  localparam int DEPTH = 1 << DMEM_ADDR_W;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } access_size_t;

  logic [7:0] mem [DEPTH];

  logic [DMEM_ADDR_W-1:0] addr;
  logic [DMEM_ADDR_W-1:0] addr_h0;
  logic [DMEM_ADDR_W-1:0] addr_h1;
  logic [DMEM_ADDR_W-1:0] addr_w0;
  logic [DMEM_ADDR_W-1:0] addr_w1;
  logic [DMEM_ADDR_W-1:0] addr_w2;
  logic [DMEM_ADDR_W-1:0] addr_w3;

  access_size_t size;
  logic         legal;
  logic         is_signed;
  logic         is_load;
  logic         addr_misaligned;
  logic         misalign;
  logic         store_en;

  logic [7:0]         byte_rd;
  logic [15:0]        half_rd;
  logic [31:0]        word_rd;
  logic [D_WIDTH-1:0] load_data;

  // Upper address bits are dropped so the memory aliases; lane addresses are
  // built by replacing the low bits, which is safe because only aligned
  // accesses ever use more than one lane.
  assign addr    = ALUResultM_i[DMEM_ADDR_W-1:0];
  assign addr_h0 = {addr[DMEM_ADDR_W-1:1], 1'b0};
  assign addr_h1 = {addr[DMEM_ADDR_W-1:1], 1'b1};
  assign addr_w0 = {addr[DMEM_ADDR_W-1:2], 2'b00};
  assign addr_w1 = {addr[DMEM_ADDR_W-1:2], 2'b01};
  assign addr_w2 = {addr[DMEM_ADDR_W-1:2], 2'b10};
  assign addr_w3 = {addr[DMEM_ADDR_W-1:2], 2'b11};

  assign ALUResultM_o = ALUResultM_i;

  // Decode funct3 into access size, signedness and legality.
  always_comb begin
    size      = SZ_WORD;
    legal     = 1'b1;
    is_signed = 1'b0;
    case (Funct3M)
      3'b000: begin size = SZ_BYTE; is_signed = 1'b1; end
      3'b001: begin size = SZ_HALF; is_signed = 1'b1; end
      3'b010: begin size = SZ_WORD; end
      3'b100: begin size = SZ_BYTE; end
      3'b101: begin size = SZ_HALF; end
      default: legal = 1'b0;
    endcase
  end

  // Alignment check and store qualification; illegal funct3 never flags misalignment.
  always_comb begin
    is_load         = (ResultSrcM_i == 2'b01);
    addr_misaligned = ((size == SZ_HALF) && addr[0]) ||
                      ((size == SZ_WORD) && (addr[1:0] != 2'b00));
    misalign        = legal && addr_misaligned && (MemWriteM || is_load);
    store_en        = MemWriteM && legal && !addr_misaligned && !rst;
  end

  // Combinational read of the addressed lanes, then extension to datapath width.
  always_comb begin
    byte_rd   = mem[addr];
    half_rd   = {mem[addr_h1], mem[addr_h0]};
    word_rd   = {mem[addr_w3], mem[addr_w2], mem[addr_w1], mem[addr_w0]};
    load_data = '0;
    if (legal && !addr_misaligned) begin
      case (size)
        SZ_BYTE: load_data = {{(D_WIDTH-8){is_signed & byte_rd[7]}}, byte_rd};
        SZ_HALF: load_data = {{(D_WIDTH-16){is_signed & half_rd[15]}}, half_rd};
        default: load_data = D_WIDTH'(word_rd);
      endcase
    end
  end

  // Little-endian byte-lane store; lanes outside the access keep their value.
  always_ff @(posedge clk) begin
    if (store_en) begin
      case (size)
        SZ_BYTE: mem[addr] <= WriteDataM[7:0];
        SZ_HALF: begin
          mem[addr_h0] <= WriteDataM[7:0];
          mem[addr_h1] <= WriteDataM[15:8];
        end
        default: begin
          mem[addr_w0] <= WriteDataM[7:0];
          mem[addr_w1] <= WriteDataM[15:8];
          mem[addr_w2] <= WriteDataM[23:16];
          mem[addr_w3] <= WriteDataM[31:24];
        end
      endcase
    end
  end

  // MEM/WB pipeline register, loaded every cycle and cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCplus4W   <= '0;
      RdW        <= '0;
      MisalignW  <= 1'b0;
    end else begin
      RegWriteW  <= RegWriteM_i;
      ResultSrcW <= ResultSrcM_i;
      ALUResultW <= ALUResultM_i;
      ReadDataW  <= load_data;
      PCplus4W   <= PCplus4M_i;
      RdW        <= RdM_i;
      MisalignW  <= misalign;
    end
  end

  // Writeback select; the reserved encoding returns zero.
  always_comb begin
    ResultW = '0;
    case (ResultSrcW)
      2'b00:   ResultW = ALUResultW;
      2'b01:   ResultW = ReadDataW;
      2'b10:   ResultW = PCplus4W;
      default: ResultW = '0;
    endcase
  end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed vector table plus randomized
// traffic compared against a byte-array reference model.
module tb_memory_stage;

  logic        clk;
  logic        rst;
  logic        reg_write_m;
  logic [1:0]  result_src_m;
  logic        mem_write_m;
  logic [2:0]  funct3_m;
  logic [31:0] alu_result_m;
  logic [31:0] write_data_m;
  logic [4:0]  rd_m;
  logic [31:0] pc_plus4_m;

  logic [31:0] alu_result_o;
  logic        reg_write_w;
  logic [1:0]  result_src_w;
  logic [31:0] alu_result_w;
  logic [31:0] read_data_w;
  logic [31:0] pc_plus4_w;
  logic [4:0]  rd_w;
  logic        misalign_w;
  logic [31:0] result_w;

  int checks;
  int failures;

  logic [7:0] mem_m [4096];

  typedef struct {
    logic        rst;
    logic        rw;
    logic [1:0]  rs;
    logic        mw;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [31:0] pc4;
    logic        chk_data;
    logic [31:0] exp_data;
    logic        exp_mis;
    logic [31:0] exp_res;
  } vec_t;

  typedef struct {
    logic [31:0] rw;
    logic [31:0] rs;
    logic [31:0] alu;
    logic [31:0] data;
    logic [31:0] pc4;
    logic [31:0] rd;
    logic [31:0] mis;
    logic [31:0] res;
  } exp_t;

  vec_t vecs[$];

  memory_stage #(
    .D_WIDTH(32),
    .A_WIDTH(5),
    .DMEM_ADDR_W(12)
  ) dut (
    .clk(clk),
    .rst(rst),
    .RegWriteM_i(reg_write_m),
    .ResultSrcM_i(result_src_m),
    .MemWriteM(mem_write_m),
    .Funct3M(funct3_m),
    .ALUResultM_i(alu_result_m),
    .WriteDataM(write_data_m),
    .RdM_i(rd_m),
    .PCplus4M_i(pc_plus4_m),
    .ALUResultM_o(alu_result_o),
    .RegWriteW(reg_write_w),
    .ResultSrcW(result_src_w),
    .ALUResultW(alu_result_w),
    .ReadDataW(read_data_w),
    .PCplus4W(pc_plus4_w),
    .RdW(rd_w),
    .MisalignW(misalign_w),
    .ResultW(result_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Number of bytes touched by an access, 0 when funct3 is illegal.
  function automatic int accessBytes(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [31:0] modelLoad(input logic [31:0] alu, input logic [2:0] f3);
    int n;
    int unsigned a;
    logic [31:0] v;
    n = accessBytes(f3);
    a = alu % 4096;
    v = 32'h0;
    if (n == 0 || (a % n) != 0) return 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(mem_m[a + i]) << (8 * i));
    if (f3 < 3'd4 && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  function automatic exp_t modelExpect(input logic r, input logic rw, input logic [1:0] rs,
                                       input logic mw, input logic [2:0] f3,
                                       input logic [31:0] alu, input logic [4:0] rd,
                                       input logic [31:0] pc4);
    exp_t e;
    int n;
    e = '{default: 32'h0};
    if (r) return e;
    n = accessBytes(f3);
    e.rw   = {31'h0, rw};
    e.rs   = {30'h0, rs};
    e.alu  = alu;
    e.pc4  = pc4;
    e.rd   = {27'h0, rd};
    e.data = modelLoad(alu, f3);
    e.mis  = (n != 0 && ((alu % 4096) % n) != 0 && (mw || rs == 2'b01)) ? 32'h1 : 32'h0;
    case (rs)
      2'b00:   e.res = alu;
      2'b01:   e.res = e.data;
      2'b10:   e.res = pc4;
      default: e.res = 32'h0;
    endcase
    return e;
  endfunction

  task automatic modelCommit(input logic r, input logic mw, input logic [2:0] f3,
                             input logic [31:0] alu, input logic [31:0] wd);
    int n;
    int unsigned a;
    n = accessBytes(f3);
    a = alu % 4096;
    if (!r && mw && n != 0 && (a % n) == 0)
      for (int i = 0; i < n; i++) mem_m[a + i] = wd[8 * i +: 8];
  endtask

  // Drive one M-stage instruction mid-cycle, check the forwarding path, then
  // advance past the next rising edge so the W outputs can be sampled.
  task automatic applyStimulus(input logic r, input logic rw, input logic [1:0] rs,
                               input logic mw, input logic [2:0] f3,
                               input logic [31:0] alu, input logic [31:0] wd,
                               input logic [4:0] rd, input logic [31:0] pc4);
    @(negedge clk);
    rst          = r;
    reg_write_m  = rw;
    result_src_m = rs;
    mem_write_m  = mw;
    funct3_m     = f3;
    alu_result_m = alu;
    write_data_m = wd;
    rd_m         = rd;
    pc_plus4_m   = pc4;
    #1;
    check("alu_fwd", alu_result_o, alu);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input exp_t e, input logic chk_data);
    check({tag, ".RegWriteW"},  {31'h0, reg_write_w},  e.rw);
    check({tag, ".ResultSrcW"}, {30'h0, result_src_w}, e.rs);
    check({tag, ".ALUResultW"}, alu_result_w,          e.alu);
    check({tag, ".PCplus4W"},   pc_plus4_w,            e.pc4);
    check({tag, ".RdW"},        {27'h0, rd_w},         e.rd);
    check({tag, ".MisalignW"},  {31'h0, misalign_w},   e.mis);
    check({tag, ".ResultW"},    result_w,              e.res);
    if (chk_data) check({tag, ".ReadDataW"}, read_data_w, e.data);
  endtask

  function automatic vec_t mkv(input logic r, input logic rw, input logic [1:0] rs,
                               input logic mw, input logic [2:0] f3,
                               input logic [31:0] alu, input logic [31:0] wd,
                               input logic [4:0] rd, input logic [31:0] pc4,
                               input logic chk, input logic [31:0] ed,
                               input logic em, input logic [31:0] er);
    vec_t v;
    v = '{rst: r, rw: rw, rs: rs, mw: mw, f3: f3, alu: alu, wd: wd, rd: rd, pc4: pc4,
          chk_data: chk, exp_data: ed, exp_mis: em, exp_res: er};
    return v;
  endfunction

  initial begin
    exp_t e;
    checks   = 0;
    failures = 0;

    vecs.push_back(mkv(0,0,2'd0,1,3'd2,32'h100,32'hDEADBEEF,5'd0,32'h10, 0,32'h0,0,32'h100));
    vecs.push_back(mkv(0,1,2'd1,0,3'd2,32'h100,32'h0,5'd5,32'h14, 1,32'hDEADBEEF,0,32'hDEADBEEF));
    vecs.push_back(mkv(0,0,2'd0,1,3'd0,32'h101,32'h80,5'd0,32'h18, 0,32'h0,0,32'h101));
    vecs.push_back(mkv(0,1,2'd1,0,3'd0,32'h101,32'h0,5'd6,32'h1C, 1,32'hFFFFFF80,0,32'hFFFFFF80));
    vecs.push_back(mkv(0,1,2'd1,0,3'd4,32'h101,32'h0,5'd6,32'h20, 1,32'h00000080,0,32'h00000080));
    vecs.push_back(mkv(0,1,2'd1,0,3'd2,32'h100,32'h0,5'd7,32'h24, 1,32'hDEAD80EF,0,32'hDEAD80EF));
    vecs.push_back(mkv(0,0,2'd0,1,3'd1,32'h202,32'h8001,5'd0,32'h28, 0,32'h0,0,32'h202));
    vecs.push_back(mkv(0,1,2'd1,0,3'd1,32'h202,32'h0,5'd8,32'h2C, 1,32'hFFFF8001,0,32'hFFFF8001));
    vecs.push_back(mkv(0,1,2'd1,0,3'd5,32'h202,32'h0,5'd8,32'h30, 1,32'h00008001,0,32'h00008001));
    vecs.push_back(mkv(0,0,2'd0,1,3'd2,32'h300,32'h11223344,5'd0,32'h34, 0,32'h0,0,32'h300));
    vecs.push_back(mkv(0,0,2'd0,1,3'd2,32'h303,32'h12345678,5'd0,32'h38, 0,32'h0,1,32'h303));
    vecs.push_back(mkv(0,1,2'd1,0,3'd2,32'h300,32'h0,5'd9,32'h3C, 1,32'h11223344,0,32'h11223344));
    vecs.push_back(mkv(0,1,2'd1,0,3'd1,32'h301,32'h0,5'd9,32'h40, 1,32'h0,1,32'h0));
    vecs.push_back(mkv(0,0,2'd0,1,3'd2,32'h1010,32'hCAFEF00D,5'd0,32'h44, 0,32'h0,0,32'h1010));
    vecs.push_back(mkv(0,1,2'd1,0,3'd2,32'hFFFFF010,32'h0,5'd10,32'h48, 1,32'hCAFEF00D,0,32'hCAFEF00D));
    vecs.push_back(mkv(1,1,2'd1,1,3'd2,32'h100,32'hFFFFFFFF,5'd7,32'h55, 1,32'h0,0,32'h0));
    vecs.push_back(mkv(0,1,2'd1,0,3'd2,32'h100,32'h0,5'd11,32'h4C, 1,32'hDEAD80EF,0,32'hDEAD80EF));
    vecs.push_back(mkv(0,1,2'd2,0,3'd2,32'h99,32'h0,5'd3,32'h44, 0,32'h0,0,32'h44));
    vecs.push_back(mkv(0,1,2'd0,0,3'd2,32'h99,32'h0,5'd3,32'h44, 0,32'h0,0,32'h99));
    vecs.push_back(mkv(0,1,2'd3,0,3'd0,32'h99,32'h0,5'd3,32'h44, 0,32'h0,0,32'h0));
    vecs.push_back(mkv(0,1,2'd1,0,3'd3,32'h100,32'h0,5'd12,32'h50, 1,32'h0,0,32'h0));
    vecs.push_back(mkv(0,0,2'd0,1,3'd6,32'h101,32'h0,5'd0,32'h54, 0,32'h0,0,32'h101));
    vecs.push_back(mkv(0,1,2'd1,0,3'd2,32'h100,32'h0,5'd13,32'h58, 1,32'hDEAD80EF,0,32'hDEAD80EF));
    vecs.push_back(mkv(0,1,2'd1,0,3'd2,32'h102,32'h0,5'd14,32'h5C, 1,32'h0,1,32'h0));
    vecs.push_back(mkv(0,1,2'd1,0,3'd0,32'h103,32'h0,5'd15,32'h60, 1,32'hFFFFFFDE,0,32'hFFFFFFDE));

    // Reset state: every W output cleared while rst is held.
    applyStimulus(1, 1, 2'd2, 0, 3'd2, 32'h1234, 32'h0, 5'd31, 32'h88);
    e = '{default: 32'h0};
    checkOutput("reset", e, 1'b1);

    // Give the whole memory known contents so every later load is predictable.
    for (int w = 0; w < 1024; w++) begin
      logic [31:0] d;
      d = $urandom();
      applyStimulus(0, 0, 2'd0, 1, 3'd2, 32'(w * 4), d, 5'd0, 32'h0);
      modelCommit(0, 1, 3'd2, 32'(w * 4), d);
    end

    // Directed vectors with hand-derived expectations.
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      string tag;
      v = vecs[i];
      tag = $sformatf("vec%0d", i);
      applyStimulus(v.rst, v.rw, v.rs, v.mw, v.f3, v.alu, v.wd, v.rd, v.pc4);
      e.rw   = v.rst ? 32'h0 : {31'h0, v.rw};
      e.rs   = v.rst ? 32'h0 : {30'h0, v.rs};
      e.alu  = v.rst ? 32'h0 : v.alu;
      e.pc4  = v.rst ? 32'h0 : v.pc4;
      e.rd   = v.rst ? 32'h0 : {27'h0, v.rd};
      e.data = v.exp_data;
      e.mis  = {31'h0, v.exp_mis};
      e.res  = v.exp_res;
      checkOutput(tag, e, v.chk_data);
      modelCommit(v.rst, v.mw, v.f3, v.alu, v.wd);
    end

    // Randomized traffic concentrated on a small window with random alias bits.
    for (int i = 0; i < 600; i++) begin
      logic        r, rw, mw;
      logic [1:0]  rs;
      logic [2:0]  f3;
      logic [31:0] alu, wd, pc4;
      logic [4:0]  rd;
      r   = ($urandom_range(0, 31) == 0);
      rw  = 1'($urandom_range(0, 1));
      rs  = 2'($urandom_range(0, 3));
      mw  = 1'($urandom_range(0, 1));
      f3  = 3'($urandom_range(0, 7));
      alu = ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      wd  = $urandom();
      rd  = 5'($urandom_range(0, 31));
      pc4 = $urandom();
      e = modelExpect(r, rw, rs, mw, f3, alu, rd, pc4);
      applyStimulus(r, rw, rs, mw, f3, alu, wd, rd, pc4);
      checkOutput($sformatf("rnd%0d", i), e, r || rs == 2'b01);
      modelCommit(r, mw, f3, alu, wd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
